// File: rtl/w_stage_grf.sv
// Writeback stage: picks WD_W, commits it to the 32x32 GRF and serves both D-stage read ports with write-through.
// Reads and forwarding are combinational; commits land on the next clk edge; no stalls or backpressure exist here.
module w_stage_grf #(
  parameter logic [31:0] LINK_OFFSET = 32'd4,
  parameter bit          DISPLAY_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RegWriteW,
  input  logic [1:0]  MemtoRegW,
  input  logic [31:0] RDW,
  input  logic [31:0] ALUoutW,
  input  logic [31:0] PC_4W,
  input  logic [31:0] ext_immW,
  input  logic [1:0]  TnewW,
  input  logic [4:0]  AwriteW,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic [31:0] WD_W,
  output logic        fwd_valid_W,
  output logic [31:0] write_count
);

  logic [31:0] grf_q [32];
  logic [31:0] write_count_q;
  logic [31:0] write_count_d;
  logic        we_eff;

  always_comb begin
    WD_W = ALUoutW;
    unique case (MemtoRegW)
      2'b00:   WD_W = ALUoutW;
      2'b01:   WD_W = RDW;
      2'b10:   WD_W = PC_4W + LINK_OFFSET;
      default: WD_W = ext_immW;
    endcase
  end

  // $0 is hardwired: a write aimed at it is dropped entirely.
  assign we_eff        = RegWriteW && (AwriteW != 5'd0);
  assign fwd_valid_W   = we_eff && (TnewW == 2'b00);
  assign write_count_d = write_count_q + 32'd1;
  assign write_count   = write_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) grf_q[i] <= '0;
      write_count_q <= '0;
    end else if (we_eff) begin
      grf_q[AwriteW] <= WD_W;
      write_count_q  <= write_count_d;
    end
  end

  // Write-through lets the D stage see the value committing this cycle.
  always_comb begin
    RD1 = '0;
    if (A1 != 5'd0) RD1 = (we_eff && (A1 == AwriteW)) ? WD_W : grf_q[A1];
  end

  always_comb begin
    RD2 = '0;
    if (A2 != 5'd0) RD2 = (we_eff && (A2 == AwriteW)) ? WD_W : grf_q[A2];
  end

  if (DISPLAY_EN) begin : g_log
    always_ff @(posedge clk) begin
      if (!reset && we_eff) $display("@%h: $%2d <= %h", PC_4W - 32'd4, AwriteW, WD_W);
    end
  end

endmodule

// File: tb/tb_w_stage_grf.sv
// Directed-vector bench for w_stage_grf.
module tb_w_stage_grf;

  logic        clk;
  logic        reset;
  logic        RegWriteW;
  logic [1:0]  MemtoRegW;
  logic [31:0] RDW;
  logic [31:0] ALUoutW;
  logic [31:0] PC_4W;
  logic [31:0] ext_immW;
  logic [1:0]  TnewW;
  logic [4:0]  AwriteW;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] WD_W;
  logic        fwd_valid_W;
  logic [31:0] write_count;

  int n_checks = 0;
  int n_fail   = 0;

  w_stage_grf #(.LINK_OFFSET(32'd4), .DISPLAY_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .RDW(RDW), .ALUoutW(ALUoutW), .PC_4W(PC_4W), .ext_immW(ext_immW),
    .TnewW(TnewW), .AwriteW(AwriteW), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .WD_W(WD_W), .fwd_valid_W(fwd_valid_W),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge and return to the negedge, where inputs change.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_w(input logic we, input logic [1:0] mtr, input logic [4:0] dst,
                       input logic [31:0] alu);
    RegWriteW = we;
    MemtoRegW = mtr;
    AwriteW   = dst;
    ALUoutW   = alu;
  endtask

  logic [31:0] sweep_exp [3];

  initial begin
    reset = 1'b1; RegWriteW = 1'b0; MemtoRegW = 2'b00; RDW = '0; ALUoutW = '0;
    PC_4W = '0; ext_immW = '0; TnewW = 2'b00; AwriteW = '0; A1 = '0; A2 = '0;
    step();
    step();
    #1;
    check("rst_count", write_count, 32'd0);
    check("rst_fwd", {31'd0, fwd_valid_W}, 32'd0);
    check("rst_wd", WD_W, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i);
      A2 = 5'(31 - i);
      #1;
      check("rst_rd1", RD1, 32'd0);
      check("rst_rd2", RD2, 32'd0);
    end

    // Bypass, then array read of $8.
    @(negedge clk);
    set_w(1'b1, 2'b00, 5'd8, 32'h1234_5678);
    A1 = 5'd8; A2 = 5'd8; TnewW = 2'b00;
    #1;
    check("byp_rd1", RD1, 32'h1234_5678);
    check("byp_rd2", RD2, 32'h1234_5678);
    check("byp_fwd", {31'd0, fwd_valid_W}, 32'd1);
    check("byp_cnt_pre", write_count, 32'd0);
    step();
    set_w(1'b0, 2'b00, 5'd8, 32'h0);
    A2 = 5'd9;
    #1;
    check("arr_rd1", RD1, 32'h1234_5678);
    check("arr_rd2_other", RD2, 32'd0);
    check("arr_count", write_count, 32'd1);
    check("nowe_fwd", {31'd0, fwd_valid_W}, 32'd0);

    // Nonzero TnewW at W suppresses forwarding but still commits.
    @(negedge clk);
    set_w(1'b1, 2'b00, 5'd9, 32'h0000_0055);
    TnewW = 2'b01;
    #1;
    check("tnew_fwd", {31'd0, fwd_valid_W}, 32'd0);
    step();
    set_w(1'b0, 2'b00, 5'd0, 32'h0);
    TnewW = 2'b00;
    #1;
    check("tnew_rd2", RD2, 32'h0000_0055);
    check("tnew_count", write_count, 32'd2);

    // Writes to $0 are discarded.
    set_w(1'b1, 2'b00, 5'd0, 32'hFFFF_FFFF);
    A1 = 5'd0;
    #1;
    check("z_rd1", RD1, 32'd0);
    check("z_fwd", {31'd0, fwd_valid_W}, 32'd0);
    check("z_wd", WD_W, 32'hFFFF_FFFF);
    step();
    set_w(1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    check("z_count", write_count, 32'd2);
    check("z_rd1_after", RD1, 32'd0);

    // Writeback source sweep into $31.
    RDW = 32'h0000_000A; PC_4W = 32'h0000_3004; ext_immW = 32'h00AB_0000;
    sweep_exp[0] = 32'h0000_000A;
    sweep_exp[1] = 32'h0000_3008;
    sweep_exp[2] = 32'h00AB_0000;
    A1 = 5'd31; A2 = 5'd8;
    for (int m = 0; m < 3; m++) begin
      set_w(1'b1, 2'(m + 1), 5'd31, 32'hDEAD_BEEF);
      #1;
      check("mux_wd", WD_W, sweep_exp[m]);
      check("mux_byp", RD1, sweep_exp[m]);
      step();
      set_w(1'b0, 2'b00, 5'd0, 32'h0);
      #1;
      check("mux_rd1", RD1, sweep_exp[m]);
      check("mux_count", write_count, 32'(3 + m));
    end
    check("mux_keep8", RD2, 32'h1234_5678);

    // Reset beats a simultaneous write.
    reset = 1'b1;
    set_w(1'b1, 2'b00, 5'd5, 32'd7);
    step();
    reset = 1'b0;
    set_w(1'b0, 2'b00, 5'd0, 32'h0);
    A1 = 5'd5; A2 = 5'd31;
    #1;
    check("rw_rd1", RD1, 32'd0);
    check("rw_rd2", RD2, 32'd0);
    check("rw_count", write_count, 32'd0);
    set_w(1'b1, 2'b00, 5'd5, 32'd7);
    step();
    set_w(1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    check("w5_rd1", RD1, 32'd7);
    check("w5_count", write_count, 32'd1);

    // Counter wrap.
    force dut.write_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.write_count_q;
    #1;
    check("wrap_pre", write_count, 32'hFFFF_FFFF);
    set_w(1'b1, 2'b00, 5'd6, 32'd3);
    A1 = 5'd6;
    step();
    set_w(1'b0, 2'b00, 5'd0, 32'h0);
    #1;
    check("wrap_count", write_count, 32'd0);
    check("wrap_rd1", RD1, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
